// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory and decode handshake bundle for pc_sequencer
interface pc_sequencer_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] pc_current;

   // sequencer side: issues fetches, presents instructions to decode
   modport master (
      output imem_req, imem_addr, instr, instr_valid, pc_current,
      input  imem_ack, imem_data, instr_ready
   );

   // memory/decode side
   modport slave (
      input  imem_req, imem_addr, instr, instr_valid, pc_current,
      output imem_ack, imem_data, instr_ready
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch sequencer: PC, instruction fetch, branch redirect, hold and halt
module pc_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        stall,
   input  logic        branch_en,
   input  logic [15:0] branch_addr,
   input  logic        halt_req,
   output logic        halted,
   pc_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state;
   logic [15:0] fetch_pc;
   logic        redirect_pending;
   logic [15:0] redirect_addr;
   logic [15:0] redirect_target;
   logic        accept;

   // a live branch pulse overrides an older latched redirect
   always_comb begin
      redirect_target = redirect_addr;
      if (branch_en) redirect_target = branch_addr;
      accept = bus.instr_valid & bus.instr_ready & ~stall;
   end

   // sequencer state machine; every output is a register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         fetch_pc         <= RESET_PC;
         redirect_pending <= 1'b0;
         redirect_addr    <= 16'h0000;
         bus.imem_req     <= 1'b0;
         bus.imem_addr    <= RESET_PC;
         bus.instr        <= 16'h0000;
         bus.instr_valid  <= 1'b0;
         bus.pc_current   <= RESET_PC;
         halted           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state         <= FETCH;
                  bus.imem_req  <= 1'b1;
                  bus.imem_addr <= fetch_pc;
               end
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  if (branch_en || redirect_pending) begin
                     // returned word belongs to the abandoned path: drop it and refetch
                     fetch_pc         <= redirect_target;
                     bus.imem_addr    <= redirect_target;
                     redirect_pending <= 1'b0;
                  end else begin
                     bus.instr       <= bus.imem_data;
                     bus.pc_current  <= fetch_pc;
                     bus.instr_valid <= 1'b1;
                     fetch_pc        <= fetch_pc + 16'd1;
                     bus.imem_req    <= 1'b0;
                     state           <= HOLD;
                  end
               end else if (branch_en) begin
                  // memory still owes the old address; remember where to go afterwards
                  redirect_pending <= 1'b1;
                  redirect_addr    <= branch_addr;
               end
            end
            HOLD: begin
               if (branch_en) begin
                  bus.instr_valid <= 1'b0;
                  fetch_pc        <= branch_addr;
                  bus.imem_req    <= 1'b1;
                  bus.imem_addr   <= branch_addr;
                  state           <= FETCH;
               end else if (accept) begin
                  bus.instr_valid <= 1'b0;
                  if (halt_req) begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end else begin
                     bus.imem_req  <= 1'b1;
                     bus.imem_addr <= fetch_pc;
                     state         <= FETCH;
                  end
               end
            end
            HALT: begin
               bus.imem_req    <= 1'b0;
               bus.instr_valid <= 1'b0;
               halted          <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        stall = 1'b0;
   logic        branch_en = 1'b0;
   logic [15:0] branch_addr = 16'h0000;
   logic        halt_req = 1'b0;
   logic        halted;
   logic        ready = 1'b1;
   logic        man_ack = 1'b0;
   logic        mem_auto = 1'b0;
   logic        auto_ack = 1'b0;
   int          auto_cnt = 0;

   logic        run_w = 1'b0;
   logic        ack_w = 1'b0;
   logic        halted_w;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] model_pc;

   pc_sequencer_if bus ();
   pc_sequencer_if bus_w ();

   assign bus.imem_ack     = mem_auto ? auto_ack : man_ack;
   assign bus.imem_data    = bus.imem_addr ^ 16'hA5A5;
   assign bus.instr_ready  = ready;
   assign bus_w.imem_ack    = ack_w;
   assign bus_w.imem_data   = bus_w.imem_addr ^ 16'hA5A5;
   assign bus_w.instr_ready = 1'b1;

   pc_sequencer #(.RESET_PC(16'h0000)) u_dut (
      .clk(clk), .rst_n(rst_n), .run(run), .stall(stall), .branch_en(branch_en),
      .branch_addr(branch_addr), .halt_req(halt_req), .halted(halted), .bus(bus)
   );

   pc_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
      .clk(clk), .rst_n(rst_n), .run(run_w), .stall(1'b0), .branch_en(1'b0),
      .branch_addr(16'h0000), .halt_req(1'b0), .halted(halted_w), .bus(bus_w)
   );

   always #5 clk = ~clk;

   // random-latency memory: answers each outstanding request after 0..3 idle cycles
   always @(posedge clk) begin
      #1;
      if (!rst_n || !mem_auto) begin
         auto_ack = 1'b0;
         auto_cnt = 0;
      end else if (auto_ack) begin
         auto_ack = 1'b0;
         auto_cnt = $urandom_range(0, 3);
      end else if (bus.imem_req) begin
         if (auto_cnt == 0) auto_ack = 1'b1;
         else auto_cnt--;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // wait for a request at address a, acknowledge it one cycle later, check the presented word
   task automatic do_fetch(input logic [15:0] a, input string tag);
      int n = 0;
      while (!bus.imem_req && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_req"}, {15'd0, bus.imem_req}, 16'd1);
      chk({tag, "_addr"}, bus.imem_addr, a);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk({tag, "_valid"}, {15'd0, bus.instr_valid}, 16'd1);
      chk({tag, "_instr"}, bus.instr, a ^ 16'hA5A5);
      chk({tag, "_pc"}, bus.pc_current, a);
      chk({tag, "_req_off"}, {15'd0, bus.imem_req}, 16'd0);
   endtask

   initial begin
      // reset state
      @(negedge clk);
      #1;
      chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
      chk("rst_addr", bus.imem_addr, 16'h0000);
      chk("rst_pc", bus.pc_current, 16'h0000);
      chk("rst_instr", bus.instr, 16'h0000);
      chk("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
      chk("rst_halted", {15'd0, halted}, 16'd0);
      chk("rst_w_addr", bus_w.imem_addr, 16'hFFFF);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_no_req", {15'd0, bus.imem_req}, 16'd0);

      // wrap-around of the fetch PC from RESET_PC=FFFF
      run_w = 1'b1;
      tick();
      chk("wrap_req", {15'd0, bus_w.imem_req}, 16'd1);
      chk("wrap_addr0", bus_w.imem_addr, 16'hFFFF);
      ack_w = 1'b1;
      tick();
      ack_w = 1'b0;
      chk("wrap_instr", bus_w.instr, 16'h5A5A);
      chk("wrap_pc", bus_w.pc_current, 16'hFFFF);
      tick();
      chk("wrap_req2", {15'd0, bus_w.imem_req}, 16'd1);
      chk("wrap_addr1", bus_w.imem_addr, 16'h0000);
      run_w = 1'b0;

      // straight-line fetch; first request one cycle after run is sampled
      run = 1'b1;
      tick();
      chk("first_req", {15'd0, bus.imem_req}, 16'd1);
      for (int i = 0; i < 4; i++) do_fetch(16'(i), $sformatf("line%0d", i));

      // branch while the fetch at 0x0004 is outstanding
      tick();
      chk("br_f_addr", bus.imem_addr, 16'h0004);
      branch_en = 1'b1;
      branch_addr = 16'h0100;
      tick();
      branch_en = 1'b0;
      chk("br_f_hold_addr", bus.imem_addr, 16'h0004);
      tick();
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("br_f_discard", {15'd0, bus.instr_valid}, 16'd0);
      chk("br_f_req", {15'd0, bus.imem_req}, 16'd1);
      chk("br_f_target", bus.imem_addr, 16'h0100);
      do_fetch(16'h0100, "br_f_word");

      // branch coinciding with the memory acknowledge
      tick();
      chk("br_ack_addr", bus.imem_addr, 16'h0101);
      branch_en = 1'b1;
      branch_addr = 16'h0010;
      man_ack = 1'b1;
      tick();
      branch_en = 1'b0;
      man_ack = 1'b0;
      chk("br_ack_valid", {15'd0, bus.instr_valid}, 16'd0);
      chk("br_ack_target", bus.imem_addr, 16'h0010);

      // branch squashes a held, stalled instruction
      ready = 1'b0;
      stall = 1'b1;
      do_fetch(16'h0010, "hold");
      ready = 1'b1;
      tick();
      chk("stall_held", {15'd0, bus.instr_valid}, 16'd1);
      chk("stall_instr", bus.instr, 16'h0010 ^ 16'hA5A5);
      branch_en = 1'b1;
      branch_addr = 16'h0200;
      tick();
      branch_en = 1'b0;
      stall = 1'b0;
      chk("squash_valid", {15'd0, bus.instr_valid}, 16'd0);
      chk("squash_req", {15'd0, bus.imem_req}, 16'd1);
      chk("squash_addr", bus.imem_addr, 16'h0200);

      // randomized traffic against an address-stream model:
      // the next word presented is the branch target after a branch, else last accepted + 1
      model_pc = 16'h0200;
      mem_auto = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if (bus.instr_valid) begin
            chk("rnd_pc", bus.pc_current, model_pc);
            chk("rnd_instr", bus.instr, model_pc ^ 16'hA5A5);
         end
         ready = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 3) == 0);
         branch_en = ($urandom_range(0, 11) == 0);
         branch_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
         if (branch_en) model_pc = branch_addr;
         else if (bus.instr_valid && ready && !stall) model_pc = model_pc + 16'd1;
         tick();
      end
      branch_en = 1'b0;
      stall = 1'b0;
      ready = 1'b1;
      mem_auto = 1'b0;

      // reset in the middle of an outstanding fetch at 0x0007
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) do_fetch(16'(i), $sformatf("pre%0d", i));
      tick();
      chk("mid_addr", bus.imem_addr, 16'h0007);
      rst_n = 1'b0;
      #1;
      chk("mid_req_drop", {15'd0, bus.imem_req}, 16'd0);
      chk("mid_addr_rst", bus.imem_addr, 16'h0000);
      run = 1'b0;
      man_ack = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("stray_req", {15'd0, bus.imem_req}, 16'd0);
      chk("stray_valid", {15'd0, bus.instr_valid}, 16'd0);
      tick();
      chk("stray_req2", {15'd0, bus.imem_req}, 16'd0);

      // halt after accepting the word at 0x0003; halt_req is already high during its fetch
      run = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) do_fetch(16'(i), $sformatf("h%0d", i));
      tick();
      ready = 1'b0;
      halt_req = 1'b1;
      do_fetch(16'h0003, "h3");
      tick();
      chk("h3_held", {15'd0, bus.instr_valid}, 16'd1);
      chk("h3_not_halted", {15'd0, halted}, 16'd0);
      ready = 1'b1;
      tick();
      chk("halted", {15'd0, halted}, 16'd1);
      chk("halt_valid", {15'd0, bus.instr_valid}, 16'd0);
      chk("halt_req_off", {15'd0, bus.imem_req}, 16'd0);
      branch_en = 1'b1;
      branch_addr = 16'h0300;
      tick();
      branch_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("halt_stay_req", {15'd0, bus.imem_req}, 16'd0);
         chk("halt_stay", {15'd0, halted}, 16'd1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port run  input  1  level; starts fetching from IDLE.
REQ-005 SHALL have port stall  input  1  level; blocks acceptance of the held instruction.
REQ-006 SHALL have port branch_en  input  1  one-cycle redirect pulse from the branch unit.
REQ-007 SHALL have port branch_addr  input  16  absolute redirect target, valid with branch_en.
REQ-008 SHALL have port halt_req  input  1  level; stop after the current instruction is accepted.
REQ-009 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-010 SHALL have port imem_addr  output  16  fetch address.
REQ-011 SHALL have port imem_ack  input  1  fetch complete; imem_data valid this cycle.
REQ-012 SHALL have port imem_data  input  16  fetched instruction word.
REQ-013 SHALL have port instr  output  16  instruction presented to decode.
REQ-014 SHALL have port instr_valid  output  1  instr valid.
REQ-015 SHALL have port instr_ready  input  1  decode accepts instr.
REQ-016 SHALL have port pc_current  output  16  address of instr; feeds the branch unit.
REQ-017 SHALL have port halted  output  1  high in HALT.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD, HALT; all outputs registered.
REQ-019 IDLE: imem_req=0; run=1 -> FETCH next cycle.
REQ-020 FETCH: imem_req=1, imem_addr=fetch_pc held stable until imem_ack.
REQ-021 FETCH, imem_ack=1, no redirect pending, branch_en=0: instr<=imem_data, pc_current<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+1 modulo 2^16 (16'hFFFF -> 16'h0000), -> HOLD.
REQ-022 FETCH, branch_en=1 with imem_ack=0: latch redirect_pending=1, redirect_addr=branch_addr; request stays outstanding at the old address.
REQ-023 FETCH, imem_ack=1 with redirect pending or branch_en=1: discard imem_data, fetch_pc<=target (branch_en's branch_addr takes priority over a latched redirect_addr), clear redirect_pending, stay FETCH; imem_req remains 1, imem_addr = target next cycle.
REQ-024 Back-to-back branch_en pulses while pending: newest branch_addr wins.
REQ-025 HOLD: imem_req=0; instr, pc_current, instr_valid held stable while not accepted.
REQ-026 HOLD, accept (instr_valid & instr_ready & !stall): instr_valid<=0; halt_req=1 -> HALT, else -> FETCH.
REQ-027 HOLD, branch_en=1: squash (instr_valid<=0 next cycle regardless of instr_ready), fetch_pc<=branch_addr, -> FETCH; branch_en beats accept and halt_req.
REQ-028 halt_req SHALL be ignored in IDLE and FETCH; it takes effect only at an accept in HOLD.
REQ-029 HALT: imem_req=0, instr_valid=0, halted=1; branch_en, run ignored; exit only via reset.
REQ-030 stall SHALL have no effect outside HOLD.
REQ-031 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, pc_current=RESET_PC, instr=16'h0000, instr_valid=0, halted=0, redirect_pending=0.
REQ-033 Reset asserted mid-fetch SHALL abandon the outstanding request; a later imem_ack is ignored (state IDLE).
REQ-034 After rst_n rises, first imem_req SHALL occur one cycle after run=1 is sampled.

Verification
REQ-035 Straight-line: run=1, ack 1 cycle after each req, data=addr^16'hA5A5, instr_ready=1 -> instr sequence for addresses 0x0000,0x0001,0x0002 with matching pc_current.
REQ-036 Wrap: RESET_PC=16'hFFFF, one fetch accepted -> next imem_addr=16'h0000.
REQ-037 Branch during outstanding fetch: req at 0x0004, branch_en with 0x0100 two cycles before ack -> word for 0x0004 never valid; next imem_addr=0x0100.
REQ-038 Branch in HOLD with stall=1: instr at 0x0010 held, branch_en with 0x0200 -> instr_valid=0 next cycle, next fetch 0x0200.
REQ-039 Halt: halt_req=1 while instr at 0x0003 held, then accepted -> halted=1, imem_req=0 permanently; later branch_en no effect.
REQ-040 Reset mid-fetch: rst_n=0 with req outstanding at 0x0007 -> imem_req=0 same cycle, imem_addr=RESET_PC; stray imem_ack ignored.
